// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle wide subtractor: diff = (a - b - bin) mod 2^W, computed one 4-bit
// slice per clock, LSB nibble first, with the borrow registered between slices.
// Each slice is a flattened two-level borrow-lookahead subtractor.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  asynchronous active-high reset
//   start  in   1  request, sampled only in IDLE or DONE
//   a      in   W  minuend, captured on the accepted start edge
//   b      in   W  subtrahend, captured on the accepted start edge
//   bin    in   1  borrow-in, captured on the accepted start edge
//   busy   out  1  high while the slices are being processed
//   done   out  1  one-cycle pulse, result valid
//   diff   out  W  result, held until the next accepted start completes
//   bout   out  1  final borrow (unsigned underflow)
//   zero   out  1  diff == 0, held with diff
module nibble_serial_subtractor #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 bin,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] diff,
   output logic                 bout,
   output logic                 zero
);

   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    acc_q;
   logic            br_q;
   logic [CW-1:0]   cnt_q;

   logic [3:0]      sa;
   logic [3:0]      sb;
   logic [3:0]      g;
   logic [3:0]      p;
   logic [3:0]      d;
   logic [4:0]      br;
   logic [W-1:0]    acc_nxt;

   // Slice datapath: borrows are expanded two-level so no bit waits on the previous one.
   always_comb begin
      sa    = a_q[3:0];
      sb    = b_q[3:0];
      g     = ~sa & sb;
      p     = ~(sa ^ sb);
      br[0] = br_q;
      br[1] = g[0] | (p[0] & br_q);
      br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_q);
      br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & br_q);
      br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & br_q);
      d     = sa ^ sb ^ br[3:0];
      // New nibble enters at the MSB end; after NIBBLES shifts the LSB nibble is at the bottom.
      acc_nxt = W'({d, acc_q} >> 4);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         bout    <= 1'b0;
         zero    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  br_q    <= bin;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StRun;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               a_q   <= a_q >> 4;
               b_q   <= b_q >> 4;
               br_q  <= br[4];
               acc_q <= acc_nxt;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_q <= StDone;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  diff    <= acc_nxt;
                  bout    <= br[4];
                  zero    <= (acc_nxt == '0);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (NIBBLES=4, W=16).
// Expected results are queued when an operation is accepted and compared when done pulses.
module tb_nibble_serial_subtractor;

   localparam int unsigned NIBBLES = 4;
   localparam int unsigned W       = 16;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         bout;
      logic         zero;
   } res_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
      logic         zero;
   } vec_t;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         zero;

   int   checks;
   int   errors;
   res_t exp_q[$];
   vec_t tbl[10];

   nibble_serial_subtractor #(.NIBBLES(NIBBLES)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      res_t e;
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("diff", {16'h0, diff}, {16'h0, e.diff});
            chk("bout", {31'h0, bout}, {31'h0, e.bout});
            chk("zero", {31'h0, zero}, {31'h0, e.zero});
         end
      end
   end

   // Drive one start; returns 1ns after the accepting edge with operands scrambled.
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input logic [W-1:0] ed, input logic eb, input logic ez,
                        input bit push);
      @(negedge clk);
      a     = ia;
      b     = ib;
      bin   = ibin;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      if (push) exp_q.push_back('{diff: ed, bout: eb, zero: ez});
   endtask

   // lat counts edges from start being raised: the accepting edge is 1.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i + 2;
            break;
         end
      end
      if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin,
                         output logic [W-1:0] ed, output logic eb, output logic ez);
      logic [W:0] full;
      full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      ed   = full[W-1:0];
      eb   = full[W];
      ez   = (full[W-1:0] == '0);
   endtask

   initial begin
      int           lat;
      int           busy_cnt;
      int           done_cnt;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbin;
      logic [W-1:0] ed;
      logic         eb;
      logic         ez;

      checks = 0;
      errors = 0;

      //          a        b        bin   diff     bout  zero
      tbl[0] = '{16'h0003, 16'h0002, 1'b0, 16'h0001, 1'b0, 1'b0};
      tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      tbl[2] = '{16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b1};
      tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[5] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0};
      tbl[6] = '{16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0};
      tbl[7] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[8] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};
      tbl[9] = '{16'h0010, 16'h0011, 1'b0, 16'hFFFF, 1'b1, 1'b0};

      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      rst   = 1'b1;
      #1;
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_diff", {16'h0, diff}, 32'd0);
      chk("rst_bout", {31'h0, bout}, 32'd0);
      chk("rst_zero", {31'h0, zero}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Table vectors, including the full and cross-nibble borrow chains.
      for (int i = 0; i < 10; i++) begin
         issue(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].diff, tbl[i].bout, tbl[i].zero, 1'b1);
         chk("busy_after_accept", {31'h0, busy}, 32'd1);
         wait_done(lat);
         chk("latency", lat, NIBBLES + 1);
      end

      // start pulsed while busy must be ignored; busy lasts exactly NIBBLES cycles.
      issue(16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1);
      busy_cnt = busy ? 1 : 0;
      done_cnt = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         start = (i == 2);
         if (i == 2) begin
            a   = 16'hFFFF;
            b   = 16'h0000;
            bin = 1'b0;
         end
         @(posedge clk);
         #1;
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
      start = 1'b0;
      chk("busy_cycles", busy_cnt, NIBBLES);
      chk("single_done", done_cnt, 1);
      repeat (3) @(posedge clk);

      // Back-to-back: start high during the DONE cycle re-enters RUN at once.
      issue(16'h0003, 16'h0002, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1);
      wait_done(lat);
      chk("latency_b2b_first", lat, NIBBLES + 1);
      issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      chk("reentry_busy", {31'h0, busy}, 32'd1);
      wait_done(lat);
      chk("latency_b2b_second", lat, NIBBLES + 1);

      // Reset during RUN cycle 2 aborts the operation with no done pulse.
      issue(16'h0000, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_busy", {31'h0, busy}, 32'd0);
      chk("abort_done", {31'h0, done}, 32'd0);
      chk("abort_diff", {16'h0, diff}, 32'd0);
      chk("abort_bout", {31'h0, bout}, 32'd0);
      chk("abort_zero", {31'h0, zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 0);
      issue(16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
      wait_done(lat);
      chk("latency_after_abort", lat, NIBBLES + 1);

      // Random operands against the wide reference.
      for (int i = 0; i < 25; i++) begin
         ra   = W'($urandom);
         rb   = (i % 5 == 0) ? ra : W'($urandom);
         rbin = 1'($urandom);
         ref_op(ra, rb, rbin, ed, eb, ez);
         issue(ra, rb, rbin, ed, eb, ez, 1'b1);
         wait_done(lat);
         chk("latency_rand", lat, NIBBLES + 1);
      end

      repeat (4) @(posedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
